flush_ctrl: RTL and testbench
=============================

FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush  in  1 each  WB flush events.
REQ-004 SHALL have ports: excp_tlbrefill  in  1  exception is TLB refill.
REQ-005 SHALL have ports: ws_pc  in  32  PC of WB instruction.
REQ-006 SHALL have ports: csr_eentry, csr_tlbrentry, csr_era_q  in  32 each  exception entry, TLB-refill entry, ERA read value.
REQ-007 SHALL have ports: icache_op_done  in  1  icache maintenance op complete; has_int  in  1  pending enabled interrupt.
REQ-008 SHALL have ports: fe_ready  in  1  fetch accepts redirect this cycle.
REQ-009 SHALL have ports: pipe_flush  out  1  kill IF..MEM; redirect_valid  out  1; redirect_pc  out  32; fetch_stall  out  1; ctrl_busy  out  1; idle_cycles  out  16  saturating idle-wait count.

Function
REQ-010 SHALL implement FSM states RUN, WAIT_ICACOP, WAIT_INT, REDIRECT.
REQ-011 SHALL drive pipe_flush = OR of all five flush inputs, combinationally, only in RUN; 0 in other states.
REQ-012 SHALL resolve simultaneous flush inputs by fixed priority excp > ertn > icacop > idle > refetch; only the winner is acted on.
REQ-013 SHALL register target in the flush cycle: excp -> csr_tlbrentry if excp_tlbrefill else csr_eentry; ertn -> csr_era_q; icacop, idle, refetch -> ws_pc + 4 (32-bit wrap, 0xFFFFFFFC+4 = 0x0).
REQ-014 SHALL transition RUN -> REDIRECT next cycle for excp, ertn, refetch; RUN -> WAIT_ICACOP for icacop; RUN -> WAIT_INT for idle.
REQ-015 SHALL leave WAIT_ICACOP for REDIRECT on the first cycle icache_op_done = 1 (done in the same cycle as entry edge is not seen; only samples while in state).
REQ-016 SHALL leave WAIT_INT for REDIRECT on the first cycle has_int = 1.
REQ-017 SHALL assert redirect_valid with redirect_pc = registered target in all REDIRECT cycles, holding both stable until fe_ready = 1; that cycle returns to RUN.
REQ-018 SHALL give minimum flush-to-redirect latency of 1 cycle (flush cycle N, redirect_valid at N+1).
REQ-019 SHALL ignore all flush inputs outside RUN.
REQ-020 SHALL assert fetch_stall and ctrl_busy in every non-RUN state; redirect_valid = 0 outside REDIRECT.
REQ-021 SHALL clear idle_cycles on entry to WAIT_INT, increment by 1 each WAIT_INT cycle, saturate at 0xFFFF, hold value after exit.

Reset
REQ-022 SHALL on reset enter RUN, clear target to 0x0 and idle_cycles to 0.
REQ-023 SHALL drive reset-state outputs: pipe_flush 0 while reset=1, redirect_valid 0, redirect_pc 0x0, fetch_stall 0, ctrl_busy 0, idle_cycles 0.
REQ-024 SHALL abandon any in-progress sequence (including mid-REDIRECT with fe_ready=0) on reset, with no redirect issued.

Structure
REQ-025 SHALL place state encoding (2-bit) and flush priority index constants in the shared mycpu package header.
REQ-026 SHALL use one sub-module flush_prio_enc: one-hot winner plus target mux, purely combinational.
REQ-027 SHALL keep FSM, target register and idle counter in flush_ctrl.

Verification
REQ-028 SHALL cover: excp_flush=1, excp_tlbrefill=0, csr_eentry=0x1C008000, fe_ready=1 -> pipe_flush same cycle, redirect_valid next cycle, redirect_pc=0x1C008000, RUN after.
REQ-029 SHALL cover: excp_flush+ertn_flush+refetch_flush together, excp_tlbrefill=1, csr_tlbrentry=0x1C00F000 -> redirect_pc=0x1C00F000 only.
REQ-030 SHALL cover: icacop_flush at ws_pc=0x1C000100, icache_op_done after 5 cycles, fe_ready low 2 cycles -> fetch_stall 8+ cycles, redirect_pc=0x1C000104 held stable.
REQ-031 SHALL cover: idle_flush, has_int after 70000 cycles -> idle_cycles=0xFFFF, redirect_pc=ws_pc+4.
REQ-032 SHALL cover: refetch_flush at ws_pc=0xFFFFFFFC -> redirect_pc=0x00000000; reset asserted in REDIRECT with fe_ready=0 -> no redirect, all outputs zero next cycle.

Source files
------------

// File: rtl/flush_ctrl_pkg.sv
// flush_ctrl_pkg: shared state encoding and flush priority indices for the flush controller
package flush_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN         = 2'd0,
      WAIT_ICACOP = 2'd1,
      WAIT_INT    = 2'd2,
      REDIRECT    = 2'd3
   } flush_state_t;
   localparam int NUM_FLUSH = 5;
   // lower index wins
   localparam int F_EXCP    = 0;
   localparam int F_ERTN    = 1;
   localparam int F_ICACOP  = 2;
   localparam int F_IDLE    = 3;
   localparam int F_REFETCH = 4;
endpackage

// File: rtl/flush_ctrl_prio_enc.sv
// flush_prio_enc: picks the winning flush as a one-hot and muxes its redirect target
module flush_prio_enc
   import flush_ctrl_pkg::*;
(
   input  logic [NUM_FLUSH-1:0] flush,
   input  logic                 excp_tlbrefill,
   input  logic [31:0]          ws_pc,
   input  logic [31:0]          csr_eentry,
   input  logic [31:0]          csr_tlbrentry,
   input  logic [31:0]          csr_era_q,
   output logic [NUM_FLUSH-1:0] win,
   output logic [31:0]          target
);
   always_comb begin
      win    = flush & ~(flush - NUM_FLUSH'(1));
      target = win[F_EXCP] ? (excp_tlbrefill ? csr_tlbrentry : csr_eentry) :
               win[F_ERTN] ? csr_era_q : ws_pc + 32'd4;
   end
endmodule

// File: rtl/flush_ctrl.sv
// flush_ctrl: sequences WB flushes into a held fetch redirect, waiting on icache ops or interrupts
module flush_ctrl
   import flush_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        excp_flush,
   input  logic        ertn_flush,
   input  logic        refetch_flush,
   input  logic        icacop_flush,
   input  logic        idle_flush,
   input  logic        excp_tlbrefill,
   input  logic [31:0] ws_pc,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_tlbrentry,
   input  logic [31:0] csr_era_q,
   input  logic        icache_op_done,
   input  logic        has_int,
   input  logic        fe_ready,
   output logic        pipe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        fetch_stall,
   output logic        ctrl_busy,
   output logic [15:0] idle_cycles
);
   flush_state_t         state;
   logic [NUM_FLUSH-1:0] flush_vec;
   logic [NUM_FLUSH-1:0] win;
   logic [31:0]          win_target;
   logic [31:0]          target;

   always_comb begin
      flush_vec            = '0;
      flush_vec[F_EXCP]    = excp_flush;
      flush_vec[F_ERTN]    = ertn_flush;
      flush_vec[F_ICACOP]  = icacop_flush;
      flush_vec[F_IDLE]    = idle_flush;
      flush_vec[F_REFETCH] = refetch_flush;
   end

   flush_prio_enc u_prio (
      .flush          (flush_vec),
      .excp_tlbrefill (excp_tlbrefill),
      .ws_pc          (ws_pc),
      .csr_eentry     (csr_eentry),
      .csr_tlbrentry  (csr_tlbrentry),
      .csr_era_q      (csr_era_q),
      .win            (win),
      .target         (win_target)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         target      <= 32'h0;
         idle_cycles <= 16'h0;
      end else begin
         case (state)
            RUN: if (|flush_vec) begin
               target <= win_target;
               state  <= win[F_ICACOP] ? WAIT_ICACOP : win[F_IDLE] ? WAIT_INT : REDIRECT;
               if (win[F_IDLE]) idle_cycles <= 16'h0;
            end
            WAIT_ICACOP: if (icache_op_done) state <= REDIRECT;
            WAIT_INT: begin
               if (idle_cycles != 16'hFFFF) idle_cycles <= idle_cycles + 16'd1;
               if (has_int) state <= REDIRECT;
            end
            REDIRECT: if (fe_ready) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // a pending reset suppresses both the kill and any redirect offered this cycle
   assign pipe_flush     = !reset && state == RUN && |flush_vec;
   assign redirect_valid = !reset && state == REDIRECT;
   assign redirect_pc    = target;
   assign fetch_stall    = state != RUN;
   assign ctrl_busy      = state != RUN;
endmodule

// File: tb/tb_flush_ctrl.sv
// tb_flush_ctrl: table-driven and hand-sequenced checks of the flush controller
module tb_flush_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
   logic        excp_tlbrefill;
   logic [31:0] ws_pc, csr_eentry, csr_tlbrentry, csr_era_q;
   logic        icache_op_done, has_int, fe_ready;
   logic        pipe_flush, redirect_valid, fetch_stall, ctrl_busy;
   logic [31:0] redirect_pc;
   logic [15:0] idle_cycles;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   typedef struct {
      logic        excp, ertn, icacop, idle, refetch, tlb;
      logic [31:0] pc, eentry, tlbr, era;
      logic        pf;
      int          st;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[8];

   flush_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .excp_flush     (excp_flush),
      .ertn_flush     (ertn_flush),
      .refetch_flush  (refetch_flush),
      .icacop_flush   (icacop_flush),
      .idle_flush     (idle_flush),
      .excp_tlbrefill (excp_tlbrefill),
      .ws_pc          (ws_pc),
      .csr_eentry     (csr_eentry),
      .csr_tlbrentry  (csr_tlbrentry),
      .csr_era_q      (csr_era_q),
      .icache_op_done (icache_op_done),
      .has_int        (has_int),
      .fe_ready       (fe_ready),
      .pipe_flush     (pipe_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_stall    (fetch_stall),
      .ctrl_busy      (ctrl_busy),
      .idle_cycles    (idle_cycles)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (fetch_stall) stall_cnt <= stall_cnt + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_flush();
      excp_flush = 0; ertn_flush = 0; refetch_flush = 0; icacop_flush = 0; idle_flush = 0;
   endtask

   task automatic apply_vec(input vec_t v, input int k);
      excp_flush = v.excp; ertn_flush = v.ertn; icacop_flush = v.icacop;
      idle_flush = v.idle; refetch_flush = v.refetch; excp_tlbrefill = v.tlb;
      ws_pc = v.pc; csr_eentry = v.eentry; csr_tlbrentry = v.tlbr; csr_era_q = v.era;
      fe_ready = 1; icache_op_done = 0; has_int = 0;
      @(negedge clk);
      chk($sformatf("v%0d_pipe_flush", k), pipe_flush, v.pf);
      step();
      clear_flush();
      @(negedge clk);
      chk($sformatf("v%0d_stall", k), fetch_stall, v.st != 0);
      chk($sformatf("v%0d_rv_early", k), redirect_valid, v.st == 3);
      if (v.st == 1) begin
         icache_op_done = 1; step(); icache_op_done = 0;
      end else if (v.st == 2) begin
         has_int = 1; step(); has_int = 0;
      end
      if (v.st != 0) begin
         if (v.st != 3) @(negedge clk);
         chk($sformatf("v%0d_rv", k), redirect_valid, 1);
         chk($sformatf("v%0d_pc", k), redirect_pc, v.exp_pc);
         step();
         @(negedge clk);
         chk($sformatf("v%0d_run_after", k), fetch_stall, 0);
      end
      step();
   endtask

   initial begin
      int s0;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C000010, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 3, 32'h1C008000};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1C000010, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 3, 32'h1C00F000};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1C000010, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 3, 32'h1C000400};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1C000100, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 1, 32'h1C000104};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1C000200, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 2, 32'h1C000204};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 3, 32'h00000000};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C000300, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b0, 0, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1C000300, 32'h1C008000, 32'h1C00F000, 32'h1C000400, 1'b1, 3, 32'h1C008000};

      reset = 1; clear_flush(); excp_flush = 1; excp_tlbrefill = 0;
      ws_pc = 0; csr_eentry = 32'h1C008000; csr_tlbrentry = 0; csr_era_q = 0;
      icache_op_done = 0; has_int = 0; fe_ready = 1;
      step(); step();
      @(negedge clk);
      chk("rst_pipe_flush", pipe_flush, 0);
      chk("rst_rv", redirect_valid, 0);
      chk("rst_pc", redirect_pc, 0);
      chk("rst_stall", fetch_stall, 0);
      chk("rst_busy", ctrl_busy, 0);
      chk("rst_idle", idle_cycles, 0);
      step();
      reset = 0; excp_flush = 0;
      step();

      for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

      // icache op: done seen at entry edge is ignored, then 5 wait cycles and 2 fe_ready-low cycles
      s0 = stall_cnt;
      icacop_flush = 1; ws_pc = 32'h1C000100; icache_op_done = 1; fe_ready = 0;
      @(negedge clk);
      chk("icop_pipe_flush", pipe_flush, 1);
      step();
      icacop_flush = 0; icache_op_done = 0; excp_flush = 1;
      @(negedge clk);
      chk("icop_wait_stall", fetch_stall, 1);
      chk("icop_ignored_flush", pipe_flush, 0);
      chk("icop_wait_rv", redirect_valid, 0);
      for (int i = 0; i < 4; i++) step();
      icache_op_done = 1;
      step();
      icache_op_done = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("icop_hold_rv%0d", i), redirect_valid, 1);
         chk($sformatf("icop_hold_pc%0d", i), redirect_pc, 32'h1C000104);
         step();
      end
      fe_ready = 1; excp_flush = 0;
      @(negedge clk);
      chk("icop_accept_pc", redirect_pc, 32'h1C000104);
      step();
      chk("icop_stall_cycles", stall_cnt - s0, 8);
      @(negedge clk);
      chk("icop_run", ctrl_busy, 0);
      step();

      // long idle saturates the counter
      idle_flush = 1; ws_pc = 32'h1C000200;
      step();
      idle_flush = 0;
      for (int i = 0; i < 70000; i++) step();
      has_int = 1;
      step();
      has_int = 0;
      @(negedge clk);
      chk("idle_sat", idle_cycles, 16'hFFFF);
      chk("idle_long_pc", redirect_pc, 32'h1C000204);
      step();
      @(negedge clk);
      chk("idle_hold_after", idle_cycles, 16'hFFFF);
      step();

      // short idle: cleared on entry, counts 3 wait cycles
      idle_flush = 1; ws_pc = 32'h1C000500;
      step();
      idle_flush = 0;
      @(negedge clk);
      chk("idle_clear", idle_cycles, 0);
      step(); step();
      has_int = 1;
      step();
      has_int = 0;
      @(negedge clk);
      chk("idle_count3", idle_cycles, 3);
      chk("idle_short_pc", redirect_pc, 32'h1C000504);
      step();

      // reset mid-redirect with fe_ready low
      ertn_flush = 1; csr_era_q = 32'h1C000400; fe_ready = 0;
      step();
      ertn_flush = 0;
      @(negedge clk);
      chk("mid_rv", redirect_valid, 1);
      step();
      reset = 1;
      @(negedge clk);
      chk("mid_rst_rv", redirect_valid, 0);
      step();
      @(negedge clk);
      chk("post_rst_rv", redirect_valid, 0);
      chk("post_rst_pc", redirect_pc, 0);
      chk("post_rst_stall", fetch_stall, 0);
      chk("post_rst_busy", ctrl_busy, 0);
      chk("post_rst_idle", idle_cycles, 0);
      step();
      reset = 0;
      step();
      @(negedge clk);
      chk("post_rst_no_redirect", redirect_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
